// File: rtl/bus_arbiter_2_pkg.sv
// bus_arbiter_2_pkg: shared state type, error word and bus widths for the two-host arbiter
package bus_arbiter_2_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam logic [DW-1:0] BUS_ERR_DATA = 32'hDEADBEEF;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/bus_arbiter_2_rr_pick2.sv
// rr_pick2: two-way round-robin selector that favours the host not served last
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);
  always_comb begin
    grant = &req ? ~last : req[1];
    valid = |req;
  end
endmodule

// File: rtl/bus_arbiter_2.sv
// bus_arbiter_2: round-robin arbiter sharing one device port between two hosts, with device timeout
module bus_arbiter_2
  import bus_arbiter_2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] h0_address,
  input  logic [DW-1:0] h0_data_write,
  input  logic [MW-1:0] h0_write_mask,
  input  logic          h0_wen,
  input  logic          h0_ren,
  output logic [DW-1:0] h0_data_read,
  output logic          h0_ready,
  input  logic [AW-1:0] h1_address,
  input  logic [DW-1:0] h1_data_write,
  input  logic [MW-1:0] h1_write_mask,
  input  logic          h1_wen,
  input  logic          h1_ren,
  output logic [DW-1:0] h1_data_read,
  output logic          h1_ready,
  output logic [AW-1:0] dev_address,
  output logic [DW-1:0] dev_data_write,
  output logic [MW-1:0] dev_write_mask,
  output logic          dev_wen,
  output logic          dev_ren,
  input  logic [DW-1:0] dev_data_read,
  input  logic          dev_ready,
  output logic          timeout_err
);
  state_t state;
  logic grant, last, pick, valid, timeout;
  logic [15:0] cnt;
  logic [DW-1:0] cap;
  logic [1:0] rdy;
  rr_pick2 u_pick (
    .req  ({h1_wen | h1_ren, h0_wen | h0_ren}),
    .last (last),
    .grant(pick),
    .valid(valid)
  );
  assign timeout = (cnt + 16'd1) == 16'(TIMEOUT_CYCLES);
  assign h0_ready = rdy[0];
  assign h1_ready = rdy[1];
  assign h0_data_read = rdy[0] ? cap : '0;
  assign h1_data_read = rdy[1] ? cap : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      cap <= '0;
      rdy <= '0;
      timeout_err <= 1'b0;
      dev_address <= '0;
      dev_data_write <= '0;
      dev_write_mask <= '0;
      dev_wen <= 1'b0;
      dev_ren <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          state <= BUSY;
          grant <= pick;
          cnt <= '0;
          dev_address <= pick ? h1_address : h0_address;
          dev_data_write <= pick ? h1_data_write : h0_data_write;
          dev_write_mask <= pick ? h1_write_mask : h0_write_mask;
          dev_wen <= pick ? h1_wen : h0_wen;
          dev_ren <= pick ? ~h1_wen & h1_ren : ~h0_wen & h0_ren;
        end
        BUSY: if (dev_ready || timeout) begin
          state <= RESP;
          cap <= dev_ready ? dev_data_read : BUS_ERR_DATA;
          timeout_err <= timeout_err | ~dev_ready;
          last <= dev_ready ? grant : last;
          rdy <= grant ? 2'b10 : 2'b01;
          dev_wen <= 1'b0;
          dev_ren <= 1'b0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        default: begin
          state <= IDLE;
          rdy <= '0;
        end
      endcase
    end
  end
endmodule

// File: doc/bus_arbiter_2.md
BUS_ARBITER_2 -- requirements
Module: bus_arbiter_2

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: device-wait limit in cycles, range 1..65535.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 hN_address  input  32  host N request address, for N = 0, 1.
REQ-005 hN_data_write  input  32  host N write data.
REQ-006 hN_write_mask  input  4  host N byte enables.
REQ-007 hN_wen / hN_ren  input  1 each  host N write/read request levels, held until hN_ready.
REQ-008 hN_data_read  output  32  host N read data, valid while hN_ready=1.
REQ-009 hN_ready  output  1  host N one-cycle completion pulse.
REQ-010 dev_address, dev_data_write, dev_write_mask, dev_wen, dev_ren  output  32/32/4/1/1  registered device-side request.
REQ-011 dev_data_read  input  32; dev_ready  input  1  device response.
REQ-012 timeout_err  output  1  sticky flag, set on any device timeout.

Function
REQ-013 FSM states: IDLE, BUSY, RESP; the grant register (0/1) and the last-served register (0/1) are held alongside the state.
REQ-014 IDLE: a host is requesting when hN_wen|hN_ren=1; the FSM stays in IDLE while no host is requesting.
REQ-015 IDLE, single requester: that host is granted.
REQ-016 IDLE, both requesting: the host other than last-served is granted (round-robin).
REQ-017 On grant, the granted host's address, data, mask and kind are latched into the dev_* registers, and the FSM enters BUSY on the next cycle.
REQ-018 Kind encoding: wen=1 gives a write (ren ignored); wen=0 with ren=1 gives a read. Exactly one of dev_wen/dev_ren is high during BUSY.
REQ-019 BUSY: the dev_* outputs stay constant and changes on the host inputs are ignored; the wait counter increments every cycle.
REQ-020 BUSY with dev_ready=1: dev_data_read is captured, dev_wen and dev_ren are cleared, last-served is set to grant, and the FSM moves to RESP.
REQ-021 BUSY with the counter reaching TIMEOUT_CYCLES and dev_ready=0: 32'hDEADBEEF is captured, timeout_err is set, dev strobes are cleared, and the FSM moves to RESP.
REQ-022 RESP lasts exactly 1 cycle: h[grant]_ready=1 and h[grant]_data_read=the captured word, then the FSM returns to IDLE.
REQ-023 The non-granted host's ready is always 0; hN_data_read=0 whenever hN_ready=0.
REQ-024 Latency: request visible in IDLE at cycle t gives dev strobe at t+1, dev_ready at cycle t+k gives host ready at t+k+1, and the FSM is in IDLE at t+k+2.
REQ-025 New requests are ignored during BUSY and RESP; a pending loser is granted at the next IDLE.
REQ-026 A dev_ready pulse received outside BUSY is ignored.
REQ-027 The wait counter is 16 bits, cleared on entry to BUSY, and never wraps (bounded by TIMEOUT_CYCLES).

Reset
REQ-028 rst=1 at any edge: FSM to IDLE; grant=0; last-served=1 (so host 0 wins the first tie); counter=0; all dev_* outputs=0; captured data=0; timeout_err=0.
REQ-029 Reset during BUSY aborts the transaction: dev strobes drop on the next cycle, and no hN_ready is issued for the aborted transaction.
REQ-030 timeout_err is cleared only by rst.

Structure
REQ-031 The shared package holds the state enum (IDLE/BUSY/RESP), the constant BUS_ERR_DATA=32'hDEADBEEF, and the 32/4-bit width constants.
REQ-032 One sub-module, rr_pick2: combinational 2-way round-robin selector (req[1:0], last → grant, valid).
REQ-033 The block drops in between the host and bus_hub_1 with no change to the device-side protocol.

Verification
REQ-034 h0 read, addr 0x100, device ready after 3 cycles with 0x12345678 -> dev_ren high for exactly the BUSY cycles; h0_ready pulses once with 0x12345678; h1_ready stays 0.
REQ-035 h0 and h1 both read from reset -> h0 is served first, then h1; with both continuously requesting, grants alternate 0,1,0,1.
REQ-036 h1 write 0xCAFEF00D, mask 4'b0011, addr 0x20, with the h1 inputs changed during BUSY -> dev_* outputs keep the latched values until dev_ready.
REQ-037 TIMEOUT_CYCLES=4, device never ready -> the host receives ready with 0xDEADBEEF; timeout_err=1 and remains 1 through further good transactions.
REQ-038 rst asserted mid-BUSY -> all outputs 0 the next cycle, no ready pulse, and a fresh request afterward completes normally.
REQ-039 wen=1 and ren=1 together -> a write is issued and dev_ren=0; a spurious dev_ready in IDLE causes no host ready.
